serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 2..32.
REQ-002 Port clk: input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-004 Port start: input, 1 bit, requests an operation; sampled only in IDLE.
REQ-005 Port sub: input, 1 bit, selects operation: 0 = a+b+cin, 1 = a-b.
REQ-006 Port a: input, WIDTH bits, first operand, sampled on the accepting edge.
REQ-007 Port b: input, WIDTH bits, second operand, sampled on the accepting edge.
REQ-008 Port cin: input, 1 bit, carry-in for addition, sampled on the accepting edge; ignored when sub=1.
REQ-009 Port busy: output, 1 bit, high while bits are being processed.
REQ-010 Port done: output, 1 bit, one-cycle pulse marking valid results.
REQ-011 Port sum: output, WIDTH bits, registered result.
REQ-012 Port cout: output, 1 bit, registered carry-out of the MSB; for sub=1, 1 means no borrow.
REQ-013 Port ovf: output, 1 bit, registered signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1 at a rising edge SHALL do all of the following: load a into shift register A; load b (or ~b when sub=1) into shift register B; load carry from cin (or 1 when sub=1); clear the bit counter; go to SHIFT.
REQ-016 Each SHIFT edge SHALL add A[0], B[0] and carry in one full-adder cell, shift the result bit into the accumulator from the MSB side, shift A and B right by one, update carry, and increment the counter.
REQ-017 On the SHIFT edge where counter = WIDTH-1, the block SHALL write the accumulator result to sum, write the final carry to cout, write ovf, and go to DONE.
REQ-018 The transition DONE -> IDLE SHALL be unconditional after one cycle.
REQ-019 Latency: done SHALL be high in the cycle beginning WIDTH edges after the accepting edge; busy SHALL be high for exactly WIDTH cycles.
REQ-020 start SHALL be ignored in SHIFT and DONE; a start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-021 Changes on a, b, sub or cin after the accepting edge SHALL NOT affect the running operation.
REQ-022 sum, cout and ovf SHALL hold their values from DONE until the next REQ-017 update.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; sum SHALL equal (a + b + cin) mod 2^WIDTH, or (a - b) mod 2^WIDTH when sub=1.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, A=0, B=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=0, SHIFT=1, DONE=2) and the counter-width function, ceil(log2(WIDTH)).
REQ-027 The per-bit cell SHALL be a sub-module full_adder (inputs a, b, cin; outputs sum, cout), instantiated exactly once.

Verification
REQ-028 The bench SHALL run with WIDTH=8, and SHALL:
- check all outputs are 0 and busy is low after reset;
- check the full_adder truth table over all 8 input combinations.
REQ-029 Add: a=0x3C, b=0x5A, cin=0, sub=0, start for one cycle -> busy for 8 cycles, then done pulse with sum=0x96, cout=0, ovf=1.
REQ-030 Wrap-around: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-031 Subtract: a=0x10, b=0x20, sub=1, with cin=1 driven and ignored -> sum=0xF0, cout=0, ovf=0; then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-032 Protocol cases:
- start pulsed during SHIFT, and operands changed during SHIFT -> result unaffected, no extra operation;
- start held high continuously -> back-to-back operations, done pulses 10 cycles apart.
REQ-033 Reset mid-operation: rst asserted 4 cycles after start -> outputs immediately 0 and no done pulse; a new start then gives a correct result after 8 cycles.
REQ-034 A randomised check of 1000 operands for each of sub=0 and sub=1 SHALL match a reference model on sum, cout and ovf.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial adder: FSM state
//                encoding and the bit-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // FSM encoding, fixed values so the state can be read off a waveform
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ceil(log2(width)): bits needed to count 0 .. width-1
    function automatic int cnt_width(input int width);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < width) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit full-adder cell used by the serial datapath.
//  Ports       : a, b, cin -> operand bits and carry in
//                sum, cout -> sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder/subtractor. One operand bit pair is
//                processed per clock, LSB first, through a single full-adder
//                cell. Subtraction is a + ~b + 1.
//  Ports       : clk, rst            -> clock, async active-high reset
//                start, sub          -> request / operation select
//                a, b, cin           -> operands and carry in (add only)
//                busy, done          -> processing flag / result pulse
//                sum, cout, ovf      -> registered result, carry, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_acc;
    logic               r_carry;
    logic [c_CW-1:0]    r_cnt;

    logic               w_s;
    logic               w_co;
    logic [WIDTH-1:0]   w_acc_next;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_co)
    );

    // New bit enters from the MSB side; the full word only exists on the
    // final step, so the accumulator keeps just the WIDTH-1 earlier bits.
    assign w_acc_next = {w_s, r_acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc   <= w_acc_next[WIDTH-1:1];
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        sum     <= w_acc_next;
                        cout    <= w_co;
                        // r_carry is the carry into the MSB on this step
                        ovf     <= r_carry ^ w_co;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int c_W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic           sub;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;
    logic           busy;
    logic           done;
    logic [c_W-1:0] sum;
    logic           cout;
    logic           ovf;

    logic           fa_a, fa_b, fa_c, fa_s, fa_co;

    int n_tests;
    int n_fail;

    serial_adder #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    full_adder u_fa_chk (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_c),
        .sum  (fa_s),
        .cout (fa_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic with sign-rule overflow
    task automatic ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic rc,
                             input logic rs, output logic [7:0] es, output logic ec,
                             output logic eo);
        logic [8:0] full;
        if (rs) begin
            full = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
            es   = full[7:0];
            eo   = (ra[7] != rb[7]) && (es[7] != ra[7]);
        end else begin
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            es   = full[7:0];
            eo   = (ra[7] == rb[7]) && (es[7] != ra[7]);
        end
        ec = full[8];
    endtask

    // One operation. With disturb set, operands are scrambled and start is
    // pulsed while the shift is in progress.
    task automatic do_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                         input logic oc, input logic os, input bit disturb);
        logic [7:0] es;
        logic       ec, eo;
        int         k, nbusy;
        ref_model(oa, ob, oc, os, es, ec, eo);
        @(negedge clk);
        a = oa; b = ob; cin = oc; sub = os; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; nbusy = 0;
        while (done !== 1'b1 && k < 20) begin
            if (busy === 1'b1) nbusy++;
            if (disturb && k == 3) begin
                a = ~oa; b = oa ^ ob; cin = ~oc; sub = ~os; start = 1'b1;
            end
            if (disturb && k == 4) start = 1'b0;
            @(negedge clk);
            k++;
        end
        check_val({tag, " done"}, {31'd0, done}, 32'd1);
        check_val({tag, " busy_cycles"}, nbusy, 8);
        check_val({tag, " sum"}, {24'd0, sum}, {24'd0, es});
        check_val({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
        check_val({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        if (disturb) begin
            @(negedge clk);
            check_val({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
            @(negedge clk);
            check_val({tag, " no_extra_op"}, {31'd0, busy}, 32'd0);
            check_val({tag, " sum_held"}, {24'd0, sum}, {24'd0, es});
        end
    endtask

    initial begin
        int cyc, d1, d2, k, nd, nb;
        n_tests = 0; n_fail = 0;
        start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        fa_a = 1'b0; fa_b = 1'b0; fa_c = 1'b0;

        // Reset state
        rst = 1'b1;
        #1;
        check_val("rst busy", {31'd0, busy}, 32'd0);
        check_val("rst done", {31'd0, done}, 32'd0);
        check_val("rst sum",  {24'd0, sum},  32'd0);
        check_val("rst cout", {31'd0, cout}, 32'd0);
        check_val("rst ovf",  {31'd0, ovf},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] e;
            v = i[2:0];
            fa_a = v[0]; fa_b = v[1]; fa_c = v[2];
            e = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
            #1;
            check_val("fa", {30'd0, fa_co, fa_s}, {30'd0, e});
        end

        // Directed operations with hand-computed results
        do_op("add", 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
        check_val("add hand_sum", {24'd0, sum}, 32'h96);
        check_val("add hand_ovf", {31'd0, ovf}, 32'd1);
        do_op("wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        check_val("wrap hand", {22'd0, cout, ovf, sum}, {22'd0, 1'b1, 1'b0, 8'h01});
        do_op("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        check_val("sub1 hand", {22'd0, cout, ovf, sum}, {22'd0, 1'b0, 1'b0, 8'hF0});
        do_op("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        check_val("sub2 hand", {22'd0, cout, ovf, sum}, {22'd0, 1'b1, 1'b1, 8'h7F});

        // Start and operand changes during SHIFT
        do_op("disturb", 8'h25, 8'h4B, 1'b1, 1'b0, 1'b1);

        // Start held high: back-to-back operations
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b1; sub = 1'b0; start = 1'b1;
        cyc = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
        end
        start = 1'b0;
        check_val("b2b second_done", {31'd0, d2 >= 0}, 32'd1);
        check_val("b2b spacing", d2 - d1, 10);
        check_val("b2b sum", {24'd0, sum}, 32'h47);

        // Reset in the middle of an operation
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst busy", {31'd0, busy}, 32'd0);
        check_val("midrst sum",  {24'd0, sum},  32'd0);
        check_val("midrst cout_ovf", {30'd0, cout, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0; nb = 0;
        for (k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
        end
        check_val("midrst no_done", nd, 0);
        check_val("midrst idle", nb, 0);
        do_op("after_rst", 8'hAA, 8'h11, 1'b0, 1'b0, 1'b0);
        check_val("after_rst hand", {24'd0, sum}, 32'hBB);

        // Randomised operands against the reference model
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 1000; n++) begin
                do_op(s ? "rnd_sub" : "rnd_add", 8'($urandom), 8'($urandom),
                      1'($urandom), s[0], 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
